// File: rtl/score_bcd_converter_if.sv
// Handshake and result bundle between the score source and the BCD converter.
// master: the score source or bench, which drives start/bin_in.
// slave:  the converter, which drives busy/done and the decimal results.
interface score_bcd_converter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     digit_en;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, digit_en, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, digit_en, overflow
  );
endinterface

// File: rtl/score_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter for the game score.
// One shift iteration runs per clock. The result, the leading-zero blank mask
// and the overflow flag are all registered together on the single done cycle.
// Values above 10^DIGITS-1 saturate to all nines.
// Optional build macro SCORE_BCD_AUTO_EN: when it is defined, the converter
// also launches whenever bin_in differs from the last launched value, so the
// display follows the score without a start strobe.
module score_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input logic                  clock,
  input logic                  reset,
  score_bcd_converter_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  // Largest value that fits in DIGITS decimal digits (10^DIGITS - 1).
  function automatic logic [63:0] max_decimal(input int digits);
    logic [63:0] lim;
    lim = 64'd1;
    for (int i = 0; i < digits; i++) begin
      lim = lim * 64'd10;
    end
    return lim - 64'd1;
  endfunction

  // Add 3 to every nibble that is 5 or more, before the next left shift.
  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // A digit is shown if it, or any more significant digit, is nonzero.
  // The units digit is always shown.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] b);
    logic [DIGITS-1:0] m;
    logic              seen;
    m    = {DIGITS{1'b0}};
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (b[4*i +: 4] != 4'd0);
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  localparam logic [63:0]       MAX_DEC_C  = max_decimal(DIGITS);
  localparam logic [BW-1:0]     NINES_C    = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] EN_RESET_C = DIGITS'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_r, next_state_s;
  logic [WIDTH-1:0]  shift_r, next_shift_s;
  logic [BW-1:0]     scratch_r, next_scratch_s;
  logic [CW-1:0]     count_r, next_count_s;
  logic              over_r, next_over_s;
  logic              busy_r, next_busy_s;
  logic              done_r, next_done_s;
  logic [BW-1:0]     bcd_r, next_bcd_s;
  logic [DIGITS-1:0] en_r, next_en_s;
  logic              ovf_r, next_ovf_s;
  logic              launch_s;
  logic              over_s;
  logic [BW-1:0]     adj_s;

`ifdef SCORE_BCD_AUTO_EN
  logic [WIDTH-1:0]  last_value_r, next_last_s;
  assign launch_s = bus.start | (bus.bin_in != last_value_r);
`else
  assign launch_s = bus.start;
`endif

  assign over_s = (64'(bus.bin_in) > MAX_DEC_C);
  assign adj_s  = dabble_adjust(scratch_r);

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bcd_out  = bcd_r;
  assign bus.digit_en = en_r;
  assign bus.overflow = ovf_r;

  // State register and all datapath/output registers, with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= {WIDTH{1'b0}};
      scratch_r <= {BW{1'b0}};
      count_r   <= {CW{1'b0}};
      over_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bcd_r     <= {BW{1'b0}};
      en_r      <= EN_RESET_C;
      ovf_r     <= 1'b0;
`ifdef SCORE_BCD_AUTO_EN
      last_value_r <= {WIDTH{1'b0}};
`endif
    end else begin
      state_r   <= next_state_s;
      shift_r   <= next_shift_s;
      scratch_r <= next_scratch_s;
      count_r   <= next_count_s;
      over_r    <= next_over_s;
      busy_r    <= next_busy_s;
      done_r    <= next_done_s;
      bcd_r     <= next_bcd_s;
      en_r      <= next_en_s;
      ovf_r     <= next_ovf_s;
`ifdef SCORE_BCD_AUTO_EN
      last_value_r <= next_last_s;
`endif
    end
  end

  // Next-state and next-register logic: launch, per-cycle dabble step, result commit.
  always_comb begin
    next_state_s   = state_r;
    next_shift_s   = shift_r;
    next_scratch_s = scratch_r;
    next_count_s   = count_r;
    next_over_s    = over_r;
    next_busy_s    = busy_r;
    next_done_s    = 1'b0;
    next_bcd_s     = bcd_r;
    next_en_s      = en_r;
    next_ovf_s     = ovf_r;
`ifdef SCORE_BCD_AUTO_EN
    next_last_s    = last_value_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          next_shift_s   = bus.bin_in;
          next_scratch_s = {BW{1'b0}};
          next_count_s   = CW'(WIDTH);
          next_over_s    = over_s;
          next_busy_s    = 1'b1;
          next_state_s   = ST_SHIFT;
`ifdef SCORE_BCD_AUTO_EN
          next_last_s    = bus.bin_in;
`endif
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Bits carried out of the top nibble are dropped; overflow is
        // already known from the launch-time compare.
        next_scratch_s = (adj_s << 1'b1) | BW'(shift_r[WIDTH-1]);
        next_shift_s   = shift_r << 1'b1;
        next_count_s   = count_r - CW'(1'b1);
        if (count_r == CW'(1'b1)) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (over_r) begin
          next_bcd_s = NINES_C;
        end else begin
          next_bcd_s = scratch_r;
        end
        next_en_s    = blank_mask(next_bcd_s);
        next_ovf_s   = over_r;
        next_done_s  = 1'b1;
        next_busy_s  = 1'b0;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
        next_busy_s  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter. A 16-bit/5-digit instance and a
// 10-bit/3-digit instance are driven from one stimulus process. Expected
// results are computed with plain decimal arithmetic and queued with the
// cycle on which done must appear. One monitor per instance compares outputs
// on every falling edge.
module tb_score_bcd_converter;
  localparam int WA = 16;
  localparam int DA = 5;
  localparam int WB = 10;
  localparam int DB = 3;

  typedef struct {
    int         due;
    logic [19:0] bcd;
    logic [4:0]  en;
    logic        ovf;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t shown_a;
  exp_t shown_b;
  logic busy_exp_a, done_exp_a, busy_exp_b, done_exp_b;

  score_bcd_converter_if #(.WIDTH(WA), .DIGITS(DA)) bus_a ();
  score_bcd_converter_if #(.WIDTH(WB), .DIGITS(DB)) bus_b ();

  score_bcd_converter #(.WIDTH(WA), .DIGITS(DA)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );
  score_bcd_converter #(.WIDTH(WB), .DIGITS(DB)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Decimal reference: saturate, split into digits, show digit i iff value >= 10^i.
  function automatic exp_t model(input int unsigned v, input int nd, input int due);
    exp_t e;
    longint unsigned lim, shown, p;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    e.due = due;
    e.ovf = (longint'(v) >= lim);
    shown = e.ovf ? lim - 1 : longint'(v);
    e.bcd = 20'd0;
    e.en  = 5'd0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      e.bcd[4*i +: 4] = 4'((shown / p) % 10);
      e.en[i] = (i == 0) || (shown >= p);
      p = p * 10;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor for the 16-bit instance.
  always @(negedge clock) begin
    if (!reset) begin
      busy_exp_a = (q_a.size() > 0) && (cyc > q_a[0].due - (WA + 2)) && (cyc < q_a[0].due);
      done_exp_a = (q_a.size() > 0) && (cyc == q_a[0].due);
      chk("busy_a", 32'(bus_a.busy), 32'(busy_exp_a));
      chk("done_a", 32'(bus_a.done), 32'(done_exp_a));
      if (bus_a.done && q_a.size() > 0) begin
        shown_a = q_a.pop_front();
        chk("bcd_a", 32'(bus_a.bcd_out), 32'(shown_a.bcd));
        chk("en_a", 32'(bus_a.digit_en), 32'(shown_a.en));
        chk("ovf_a", 32'(bus_a.overflow), 32'(shown_a.ovf));
      end else if (!bus_a.done) begin
        if (q_a.size() > 0 && cyc >= q_a[0].due) void'(q_a.pop_front());
        chk("hold_bcd_a", 32'(bus_a.bcd_out), 32'(shown_a.bcd));
        chk("hold_en_a", 32'(bus_a.digit_en), 32'(shown_a.en));
        chk("hold_ovf_a", 32'(bus_a.overflow), 32'(shown_a.ovf));
      end else begin
        busy_exp_a = 1'b0;
      end
    end
  end

  // Monitor for the 10-bit instance.
  always @(negedge clock) begin
    if (!reset) begin
      busy_exp_b = (q_b.size() > 0) && (cyc > q_b[0].due - (WB + 2)) && (cyc < q_b[0].due);
      done_exp_b = (q_b.size() > 0) && (cyc == q_b[0].due);
      chk("busy_b", 32'(bus_b.busy), 32'(busy_exp_b));
      chk("done_b", 32'(bus_b.done), 32'(done_exp_b));
      if (bus_b.done && q_b.size() > 0) begin
        shown_b = q_b.pop_front();
        chk("bcd_b", 32'(bus_b.bcd_out), 32'(shown_b.bcd));
        chk("en_b", 32'(bus_b.digit_en), 32'(shown_b.en));
        chk("ovf_b", 32'(bus_b.overflow), 32'(shown_b.ovf));
      end else if (!bus_b.done) begin
        if (q_b.size() > 0 && cyc >= q_b[0].due) void'(q_b.pop_front());
        chk("hold_bcd_b", 32'(bus_b.bcd_out), 32'(shown_b.bcd));
        chk("hold_en_b", 32'(bus_b.digit_en), 32'(shown_b.en));
        chk("hold_ovf_b", 32'(bus_b.overflow), 32'(shown_b.ovf));
      end else begin
        busy_exp_b = 1'b0;
      end
    end
  end

  task automatic launch_a(input int unsigned v);
    bus_a.bin_in = 16'(v);
    bus_a.start  = 1'b1;
    q_a.push_back(model(v, DA, cyc + WA + 2));
    tick(1);
    bus_a.start  = 1'b0;
  endtask

  task automatic launch_b(input int unsigned v);
    bus_b.bin_in = 10'(v);
    bus_b.start  = 1'b1;
    q_b.push_back(model(v, DB, cyc + WB + 2));
    tick(1);
    bus_b.start  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && n < 200) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", 32'(q_a.size() + q_b.size()), 32'd0);
    q_a.delete();
    q_b.delete();
    tick(2);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus_a.start  = 1'b0;
    bus_b.start  = 1'b0;
    bus_a.bin_in = 16'd0;
    bus_b.bin_in = 10'd0;
    q_a.delete();
    q_b.delete();
    shown_a = model(0, DA, 0);
    shown_b = model(0, DB, 0);
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned v;
    shown_a = model(0, DA, 0);
    shown_b = model(0, DB, 0);
    // Reset with a pending start; nothing may launch.
    reset        = 1'b1;
    bus_a.start  = 1'b1;
    bus_a.bin_in = 16'd500;
    bus_b.start  = 1'b1;
    bus_b.bin_in = 10'd500;
    tick(3);
    reset        = 1'b0;
    bus_a.start  = 1'b0;
    bus_a.bin_in = 16'd0;
    bus_b.start  = 1'b0;
    bus_b.bin_in = 10'd0;
    tick(3);

    // Directed corner values, then random scores.
    launch_a(1234);  wait_idle();
    launch_a(0);     wait_idle();
    launch_a(65535); wait_idle();
    for (int i = 0; i < 20; i++) begin
      launch_a($urandom_range(0, 65535));
      wait_idle();
    end

    // A second start while busy is ignored; bin_in changes mid-shift do not matter.
    launch_a(1234);
    tick(4);
    bus_a.start  = 1'b1;
    bus_a.bin_in = 16'd99;
    tick(1);
    bus_a.start  = 1'b0;
    bus_a.bin_in = 16'd1234;
    wait_idle();
    tick(30);

    // start held high: back-to-back conversions every WIDTH+2 cycles.
    v = $urandom_range(0, 65535);
    bus_a.bin_in = 16'(v);
    bus_a.start  = 1'b1;
    q_a.push_back(model(v, DA, cyc + WA + 2));
    q_a.push_back(model(v, DA, cyc + 2 * (WA + 2)));
    tick(WA + 3);
    bus_a.start = 1'b0;
    wait_idle();

    // Reset in the middle of a conversion: no done, outputs back to reset values.
    launch_a(4321);
    tick(7);
    do_reset();
    tick(30);

    // Change of bin_in without start.
    launch_a(0);
    wait_idle();
    bus_a.bin_in = 16'd7;
`ifdef SCORE_BCD_AUTO_EN
    q_a.push_back(model(7, DA, cyc + WA + 2));
`endif
    tick(40);
    bus_a.bin_in = 16'd8;
`ifdef SCORE_BCD_AUTO_EN
    q_a.push_back(model(8, DA, cyc + WA + 2));
`endif
    tick(40);
    wait_idle();

    // Narrow instance: saturation boundary and random values.
    launch_b(1000); wait_idle();
    launch_b(999);  wait_idle();
    launch_b(7);    wait_idle();
    launch_b(1023); wait_idle();
    launch_b(0);    wait_idle();
    for (int i = 0; i < 15; i++) begin
      launch_b($urandom_range(0, 1023));
      wait_idle();
    end

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
